// File: rtl/audio_pingpong_buffer_pkg.sv
// Shared constants and types for the audio ping-pong buffer and the capture stage it feeds.
package audio_pingpong_buffer_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_HALF_LEN   = 600;
    localparam int unsigned DEF_CAP_LEN    = 1200;
    localparam int unsigned DEF_P_SHIFT    = 14;
    localparam int unsigned P_WIDTH        = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } burst_state_e;

    typedef enum logic {
        BANK_1 = 1'b0,
        BANK_2 = 1'b1
    } bank_sel_e;

    // Newest-bank status published on every completion.
    typedef struct packed {
        logic               flag_new_1;
        logic               flag_new_2;
        logic [P_WIDTH-1:0] p;
    } frame_status_t;

endpackage

// File: rtl/pingpong_bank_ram.sv
// One half-frame bank: single write port, registered synchronous read (old data on same-address collision).
module pingpong_bank_ram #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DEPTH      = 600
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Out-of-range addresses simply hold the previous read value.
    always_comb begin
        rd_data_d = rd_data_q;
        if (32'(rd_addr) < DEPTH) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/audio_pingpong_buffer.sv
// Ping-pong sample buffer: fills two banks alternately, publishes newest bank, mean-amplitude metric
// and a fixed-length capture burst once both banks hold data.
module audio_pingpong_buffer
    import audio_pingpong_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned HALF_LEN   = DEF_HALF_LEN,
    parameter int unsigned CAP_LEN    = DEF_CAP_LEN,
    parameter int unsigned P_SHIFT    = DEF_P_SHIFT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  buf_clr,
    input  logic                  sample_valid,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_1,
    output logic [DATA_WIDTH-1:0] rd_data_1,
    input  logic [ADDR_WIDTH-1:0] rd_addr_2,
    output logic [DATA_WIDTH-1:0] rd_data_2,
    output logic                  flag_new_1,
    output logic                  flag_new_2,
    output logic [P_WIDTH-1:0]    p,
    output logic                  capture_en,
    output logic                  bank_done,
    output logic                  overrun
);

    localparam int unsigned ACC_W = DATA_WIDTH + ADDR_WIDTH;
    localparam int unsigned CNT_W = $clog2(CAP_LEN);
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(HALF_LEN - 1);
    localparam logic [CNT_W-1:0]      LAST_CNT = CNT_W'(CAP_LEN - 1);
    localparam logic [DATA_WIDTH-1:0] S_MIN    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] S_MAX    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [ACC_W-1:0]      P_CEIL   = ACC_W'((1 << P_WIDTH) - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    bank_sel_e             bank_q, bank_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    frame_status_t         status_q, status_d;
    logic                  primed_q, primed_d;
    logic                  bank_done_q, bank_done_d;
    logic                  overrun_q, overrun_d;
    burst_state_e          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] abs_mag;
    logic [ACC_W-1:0]      acc_sum;
    logic [ACC_W-1:0]      acc_shift;
    logic [P_WIDTH-1:0]    p_new;
    logic                  complete;
    logic                  wr_en_1, wr_en_2;

    // |sample| with the most negative code clamped so it fits the positive range.
    always_comb begin
        if (sample_data == S_MIN) begin
            abs_mag = S_MAX;
        end else if (sample_data[DATA_WIDTH-1]) begin
            abs_mag = ~sample_data + DATA_WIDTH'(1);
        end else begin
            abs_mag = sample_data;
        end
    end

    assign acc_sum   = acc_q + ACC_W'(abs_mag);
    assign acc_shift = acc_sum >> P_SHIFT;
    assign p_new     = (acc_shift > P_CEIL) ? P_WIDTH'(P_CEIL) : P_WIDTH'(acc_shift);
    assign complete  = sample_valid && (wr_ptr_q == LAST_PTR);

    // Write pointer, bank select, accumulator and newest-bank status.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        bank_d      = bank_q;
        acc_d       = acc_q;
        status_d    = status_q;
        primed_d    = primed_q;
        bank_done_d = 1'b0;
        if (buf_clr) begin
            wr_ptr_d = '0;
            bank_d   = BANK_1;
            acc_d    = '0;
            status_d = '0;
            primed_d = 1'b0;
        end else if (sample_valid) begin
            acc_d    = acc_sum;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (complete) begin
                wr_ptr_d            = '0;
                acc_d               = '0;
                bank_d              = (bank_q == BANK_1) ? BANK_2 : BANK_1;
                bank_done_d         = 1'b1;
                status_d.flag_new_1 = (bank_q == BANK_1);
                status_d.flag_new_2 = (bank_q == BANK_2);
                status_d.p          = p_new;
                // Bank 2 only ever completes after bank 1 has.
                primed_d            = primed_q || (bank_q == BANK_2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            bank_q      <= BANK_1;
            acc_q       <= '0;
            status_q    <= '0;
            primed_q    <= 1'b0;
            bank_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            bank_q      <= bank_d;
            acc_q       <= acc_d;
            status_q    <= status_d;
            primed_q    <= primed_d;
            bank_done_q <= bank_done_d;
            overrun_q   <= overrun_d;
            cnt_q       <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (buf_clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (complete && primed_d) state_d = ST_RUN;
                ST_RUN:  if (!complete && (cnt_q == LAST_CNT)) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A completion inside a burst restarts the count and flags the overrun.
    always_comb begin
        cnt_d     = cnt_q;
        overrun_d = 1'b0;
        if (buf_clr) begin
            cnt_d = '0;
        end else if (complete && ((state_q == ST_RUN) || primed_d)) begin
            cnt_d     = '0;
            overrun_d = (state_q == ST_RUN);
        end else if (state_q == ST_RUN) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign wr_en_1 = sample_valid && !buf_clr && (bank_q == BANK_1);
    assign wr_en_2 = sample_valid && !buf_clr && (bank_q == BANK_2);

    pingpong_bank_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (HALF_LEN)
    ) u_bank_1 (
        .clk    (clk),
        .wr_en  (wr_en_1),
        .wr_addr(wr_ptr_q),
        .wr_data(sample_data),
        .rd_addr(rd_addr_1),
        .rd_data(rd_data_1)
    );

    pingpong_bank_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH     (HALF_LEN)
    ) u_bank_2 (
        .clk    (clk),
        .wr_en  (wr_en_2),
        .wr_addr(wr_ptr_q),
        .wr_data(sample_data),
        .rd_addr(rd_addr_2),
        .rd_data(rd_data_2)
    );

    assign flag_new_1 = status_q.flag_new_1;
    assign flag_new_2 = status_q.flag_new_2;
    assign p          = status_q.p;
    assign capture_en = (state_q == ST_RUN);
    assign bank_done  = bank_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_audio_pingpong_buffer.sv
// Self-checking bench for audio_pingpong_buffer: directed scenarios, read table and a random phase
// compared against a sample-count based reference model.
module tb_audio_pingpong_buffer;

    localparam int HALF = 600;
    localparam int CAP  = 1200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        buf_clr;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic [9:0]  rd_addr_1, rd_addr_2;
    logic [15:0] rd_data_1, rd_data_2;
    logic        flag_new_1, flag_new_2;
    logic [9:0]  p;
    logic        capture_en, bank_done, overrun;

    always #5 clk = ~clk;

    audio_pingpong_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .buf_clr     (buf_clr),
        .sample_valid(sample_valid),
        .sample_data (sample_data),
        .rd_addr_1   (rd_addr_1),
        .rd_data_1   (rd_data_1),
        .rd_addr_2   (rd_addr_2),
        .rd_data_2   (rd_data_2),
        .flag_new_1  (flag_new_1),
        .flag_new_2  (flag_new_2),
        .p           (p),
        .capture_en  (capture_en),
        .bank_done   (bank_done),
        .overrun     (overrun)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: sample counts, per-bank arrays and a remaining-burst-cycles counter.
    logic [15:0] m_mem1 [HALF];
    logic [15:0] m_mem2 [HALF];
    bit          m_known1 [HALF];
    bit          m_known2 [HALF];
    int          m_fill, m_bank, m_done_cnt, m_left, m_p;
    longint      m_acc;
    bit          m_flag1, m_flag2, m_done, m_over;
    logic [15:0] exp_rd1, exp_rd2;
    bit          exp_ok1, exp_ok2;

    function automatic int abs_sat(input logic [15:0] d);
        int s;
        s = int'($signed(d));
        if (s == -32768) return 32767;
        return (s < 0) ? -s : s;
    endfunction

    task automatic model_clear();
        m_fill = 0; m_bank = 1; m_acc = 0; m_done_cnt = 0; m_left = 0;
        m_flag1 = 0; m_flag2 = 0; m_p = 0; m_done = 0; m_over = 0;
        exp_ok1 = 0; exp_ok2 = 0;
    endtask

    task automatic model_step(input bit v, input logic [15:0] d, input bit clr, input int a1, input int a2);
        bit burst_was;
        exp_ok1 = 0;
        exp_ok2 = 0;
        if (a1 < HALF) begin exp_ok1 = m_known1[a1]; exp_rd1 = m_mem1[a1]; end
        if (a2 < HALF) begin exp_ok2 = m_known2[a2]; exp_rd2 = m_mem2[a2]; end
        m_done = 0;
        m_over = 0;
        if (clr) begin
            m_fill = 0; m_bank = 1; m_acc = 0; m_done_cnt = 0; m_left = 0;
            m_flag1 = 0; m_flag2 = 0; m_p = 0;
            return;
        end
        burst_was = (m_left > 0);
        if (m_left > 0) m_left--;
        if (v) begin
            if (m_bank == 1) begin m_mem1[m_fill] = d; m_known1[m_fill] = 1; end
            else             begin m_mem2[m_fill] = d; m_known2[m_fill] = 1; end
            m_acc += abs_sat(d);
            m_fill++;
            if (m_fill == HALF) begin
                m_done  = 1;
                m_flag1 = (m_bank == 1);
                m_flag2 = (m_bank == 2);
                m_p     = (m_acc / 16384 > 1023) ? 1023 : int'(m_acc / 16384);
                m_acc   = 0;
                m_fill  = 0;
                m_bank  = (m_bank == 1) ? 2 : 1;
                m_done_cnt++;
                if (m_done_cnt >= 2) begin
                    m_over = burst_was;
                    m_left = CAP;
                end
            end
        end
    endtask

    task automatic drive_cycle(input bit v, input logic [15:0] d, input bit clr, input int a1, input int a2);
        logic [14:0] exp_ctrl;
        sample_valid = v;
        sample_data  = d;
        buf_clr      = clr;
        rd_addr_1    = 10'(a1);
        rd_addr_2    = 10'(a2);
        model_step(v, d, clr, a1, a2);
        @(posedge clk);
        #1;
        exp_ctrl = {m_flag1, m_flag2, 10'(m_p), (m_left > 0), m_done, m_over};
        chk("ctrl", 32'({flag_new_1, flag_new_2, p, capture_en, bank_done, overrun}), 32'(exp_ctrl));
        if (exp_ok1) chk("rd1", 32'(rd_data_1), 32'(exp_rd1));
        if (exp_ok2) chk("rd2", 32'(rd_data_2), 32'(exp_rd2));
    endtask

    task automatic async_reset(input string name);
        sample_valid = 0;
        buf_clr      = 0;
        #2;
        rst_n = 0;
        #1;
        chk(name, 32'({flag_new_1, flag_new_2, p, capture_en, bank_done, overrun}), 32'd0);
        model_clear();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic feed(input int n, input logic [15:0] d, input bit rnd);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b1, rnd ? 16'($urandom) : d, 1'b0,
                        int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end
    endtask

    typedef struct {
        int          a1;
        int          a2;
        logic [15:0] e1;
        logic [15:0] e2;
    } rd_vec_t;

    rd_vec_t vecs [4];

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n, ovr, low;

        rst_n = 0; buf_clr = 0; sample_valid = 0; sample_data = '0;
        rd_addr_1 = '0; rd_addr_2 = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({flag_new_1, flag_new_2, p, capture_en, bank_done, overrun}), 32'd0);
        rst_n = 1;

        // 1: first bank, no burst yet
        feed(HALF, 16'd100, 0);
        chk("t1_done", 32'(bank_done), 32'd1);
        chk("t1_flags", 32'({flag_new_1, flag_new_2}), 32'b10);
        chk("t1_p", 32'(p), 32'd3);
        chk("t1_cap", 32'(capture_en), 32'd0);

        // 2: second bank primes and launches a full-length burst
        feed(HALF, 16'hFC18, 0);
        chk("t2_flags", 32'({flag_new_1, flag_new_2}), 32'b01);
        chk("t2_p", 32'(p), 32'd36);
        chk("t2_ovr", 32'(overrun), 32'd0);
        n = capture_en ? 1 : 0;
        for (int i = 0; i < CAP + 100; i++) begin
            drive_cycle(1'b0, 16'h0, 1'b0, 0, 0);
            if (!capture_en) break;
            n++;
        end
        chk("t2_burst_len", 32'(n), 32'(CAP));

        // 3: table-driven reads
        vecs[0] = '{a1: 0,   a2: 5,   e1: 16'd100, e2: 16'hFC18};
        vecs[1] = '{a1: 599, a2: 599, e1: 16'd100, e2: 16'hFC18};
        vecs[2] = '{a1: 300, a2: 0,   e1: 16'd100, e2: 16'hFC18};
        vecs[3] = '{a1: 1,   a2: 598, e1: 16'd100, e2: 16'hFC18};
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b0, 16'h0, 1'b0, vecs[i].a1, vecs[i].a2);
            chk($sformatf("t3_rd1_%0d", i), 32'(rd_data_1), 32'(vecs[i].e1));
            chk($sformatf("t3_rd2_%0d", i), 32'(rd_data_2), 32'(vecs[i].e2));
        end

        // 4: full-scale negative samples saturate p; same-address read returns old data
        drive_cycle(1'b1, 16'h8000, 1'b0, 0, 0);
        chk("t4_rd_old", 32'(rd_data_1), 32'd100);
        drive_cycle(1'b1, 16'h8000, 1'b0, 0, 0);
        chk("t4_rd_new", 32'(rd_data_1), 32'h8000);
        feed(HALF - 2, 16'h8000, 0);
        chk("t4_p", 32'(p), 32'd1023);
        chk("t4_flags", 32'({flag_new_1, flag_new_2}), 32'b10);
        chk("t4_cap", 32'(capture_en), 32'd1);
        chk("t4_ovr", 32'(overrun), 32'd0);

        // 5: back-to-back completions keep the burst alive
        ovr = 0;
        low = 0;
        for (int i = 0; i < 3 * HALF; i++) begin
            drive_cycle(1'b1, 16'($urandom), 1'b0, int'($urandom_range(0, 599)), int'($urandom_range(0, 599)));
            if (overrun) ovr++;
            if (!capture_en) low++;
        end
        chk("t5_overruns", 32'(ovr), 32'd3);
        chk("t5_cap_low", 32'(low), 32'd0);

        // random phase against the model
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] d;
            case ($urandom_range(0, 7))
                0:       d = 16'h8000;
                1:       d = 16'h7FFF;
                default: d = 16'($urandom);
            endcase
            drive_cycle($urandom_range(0, 9) < 7, d, $urandom_range(0, 599) == 0,
                        int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
        end

        // 6: asynchronous reset mid-bank and mid-burst
        async_reset("t6_rst_a");
        feed(HALF + 300, 16'h0, 1);
        async_reset("t6_rst_midbank");
        feed(2 * HALF, 16'h0, 1);
        for (int i = 0; i < 10; i++) drive_cycle(1'b0, 16'h0, 1'b0, 0, 0);
        chk("t6_cap_pre", 32'(capture_en), 32'd1);
        async_reset("t6_rst_midburst");
        feed(HALF, 16'h0, 1);
        chk("t6_flags", 32'({flag_new_1, flag_new_2}), 32'b10);
        chk("t6_done", 32'(bank_done), 32'd1);
        chk("t6_cap", 32'(capture_en), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
